// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared stall encodings, sequencer states and counter width
// for the pipeline stall controller.
package pipe_stall_ctrl_pkg;
    localparam int MC_CNT_W = 6;
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;
    // Each pattern stops stages 0..k and lets stage k+1 take a bubble.
    localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
    localparam logic [5:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_EX   = {{2{NOSTOP}}, {4{STOP}}};
    localparam logic [5:0] STALL_MEM  = {NOSTOP, {5{STOP}}};
    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;
endpackage

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// pipe_stall_ctrl_mc_seq: IDLE/BUSY/DONE sequencer that holds EX for multi-cycle
// operations and reports the current cycle index and completion.
module pipe_stall_ctrl_mc_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = MC_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_cancel,
    input  logic             i_mem_stall,
    output logic             o_stallreq_ex,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt
);
    mc_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_len, w_len_nxt, w_last;

    assign w_last = r_len - CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        o_stallreq_ex = 1'b0;
        o_done        = 1'b0;
        o_cnt         = r_cnt;
        o_busy        = (r_state == MC_BUSY);
        case (r_state)
            MC_IDLE: begin
                o_cnt = '0;
                if (i_start && i_len >= CNT_W'(2)) begin
                    o_stallreq_ex = 1'b1;
                    w_state_nxt   = MC_BUSY;
                    w_cnt_nxt     = CNT_W'(1);
                    w_len_nxt     = i_len;
                end else if (i_start) begin
                    o_done = 1'b1;
                end
            end
            MC_BUSY: begin
                if (r_cnt < w_last) begin
                    o_stallreq_ex = 1'b1;
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end else begin
                    o_done      = 1'b1;
                    w_state_nxt = i_mem_stall ? MC_DONE : MC_IDLE;
                    w_cnt_nxt   = i_mem_stall ? r_cnt : '0;
                end
            end
            MC_DONE: begin
                // start still belongs to the finished instruction held by MEM
                o_done = 1'b1;
                if (!i_mem_stall) begin
                    w_state_nxt = MC_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = MC_IDLE;
        endcase
        if (i_cancel) begin
            w_state_nxt   = MC_IDLE;
            w_cnt_nxt     = '0;
            o_stallreq_ex = 1'b0;
            o_done        = 1'b0;
        end
    end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/MEM stall requests with the EX multi-cycle sequencer
// into the 6-bit pipeline stall vector.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = MC_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_mem,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    input  logic             ex_mc_cancel,
    output logic [5:0]       stall,
    output logic             ex_mc_busy,
    output logic             ex_mc_done,
    output logic [CNT_W-1:0] ex_mc_cnt
);
    logic             w_stallreq_ex, w_busy, w_done;
    logic [CNT_W-1:0] w_cnt;

    pipe_stall_ctrl_mc_seq #(.CNT_W(CNT_W)) u_mc_seq (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .i_start       (ex_mc_start),
        .i_len         (ex_mc_len),
        .i_cancel      (ex_mc_cancel),
        .i_mem_stall   (stallreq_from_mem),
        .o_stallreq_ex (w_stallreq_ex),
        .o_busy        (w_busy),
        .o_done        (w_done),
        .o_cnt         (w_cnt)
    );

    // Reset gates every output so nothing stalls while the core is held.
    assign stall = !Rst_n            ? STALL_NONE :
                   stallreq_from_mem ? STALL_MEM  :
                   w_stallreq_ex     ? STALL_EX   :
                   stallreq_from_id  ? STALL_ID   : STALL_NONE;
    assign ex_mc_busy = Rst_n && w_busy;
    assign ex_mc_done = Rst_n && w_done;
    assign ex_mc_cnt  = Rst_n ? w_cnt : '0;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios for the stall controller; inputs change on
// the falling edge and outputs are checked 1 ns later.
module tb_pipe_stall_ctrl;
    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       stallreq_from_id, stallreq_from_mem, ex_mc_start, ex_mc_cancel;
    logic [5:0] ex_mc_len;
    logic [5:0] stall;
    logic       ex_mc_busy, ex_mc_done;
    logic [5:0] ex_mc_cnt;
    int         vecs = 0;
    int         miss = 0;

    pipe_stall_ctrl dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_mem (stallreq_from_mem),
        .ex_mc_start       (ex_mc_start),
        .ex_mc_len         (ex_mc_len),
        .ex_mc_cancel      (ex_mc_cancel),
        .stall             (stall),
        .ex_mc_busy        (ex_mc_busy),
        .ex_mc_done        (ex_mc_done),
        .ex_mc_cnt         (ex_mc_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic drive(input logic rst_n, input logic id, input logic mem,
                         input logic start, input logic [5:0] len, input logic cancel);
        @(negedge Clk);
        Rst_n = rst_n;
        stallreq_from_id = id;
        stallreq_from_mem = mem;
        ex_mc_start = start;
        ex_mc_len = len;
        ex_mc_cancel = cancel;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0);
            vecs++;
            if ({stall, ex_mc_done, ex_mc_busy, ex_mc_cnt} !== 14'd0) begin
                miss++;
                $display("FAIL reset[%0d]: stall=%b done=%b busy=%b cnt=%0d, need all zero", i, stall, ex_mc_done, ex_mc_busy, ex_mc_cnt);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
            vecs++;
            if ({stall, ex_mc_done, ex_mc_busy, ex_mc_cnt} !== 14'd0) begin
                miss++;
                $display("FAIL post_reset[%0d]: stall=%b done=%b busy=%b cnt=%0d, need all zero", i, stall, ex_mc_done, ex_mc_busy, ex_mc_cnt);
            end
        end
    endtask

    // Runs one uninterrupted op of length len from IDLE; id is held throughout.
    task automatic run_op(input string nm, input logic [5:0] len, input logic id);
        logic [5:0] exp_stall;
        for (int k = 0; k < len; k++) begin
            drive(1'b1, id, 1'b0, 1'b1, len, 1'b0);
            exp_stall = (k < len - 1) ? 6'b001111 : (id ? 6'b000111 : 6'b000000);
            vecs++;
            if (stall !== exp_stall || ex_mc_cnt !== 6'(k) || ex_mc_done !== (k == len - 1) || ex_mc_busy !== (k != 0)) begin
                miss++;
                $display("FAIL %s cyc%0d: stall=%b cnt=%0d done=%b busy=%b, need stall=%b cnt=%0d done=%b busy=%b",
                         nm, k, stall, ex_mc_cnt, ex_mc_done, ex_mc_busy, exp_stall, k, k == len - 1, k != 0);
            end
        end
    endtask

    task automatic check_idle(input string nm);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        vecs++;
        if ({stall, ex_mc_done, ex_mc_busy, ex_mc_cnt} !== 14'd0) begin
            miss++;
            $display("FAIL %s idle: stall=%b done=%b busy=%b cnt=%0d, need all zero", nm, stall, ex_mc_done, ex_mc_busy, ex_mc_cnt);
        end
    endtask

    task automatic test_len2();
        run_op("len2", 6'd2, 1'b0);
        check_idle("len2");
    endtask

    task automatic test_div34();
        run_op("div34", 6'd34, 1'b0);
        check_idle("div34");
    endtask

    task automatic test_single_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
        vecs++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1 || ex_mc_busy !== 1'b0 || ex_mc_cnt !== 6'd0) begin
            miss++;
            $display("FAIL single_len1: stall=%b done=%b busy=%b cnt=%0d, need 000000 1 0 0", stall, ex_mc_done, ex_mc_busy, ex_mc_cnt);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        vecs++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1 || ex_mc_busy !== 1'b0) begin
            miss++;
            $display("FAIL single_len0: stall=%b done=%b busy=%b, need 000000 1 0", stall, ex_mc_done, ex_mc_busy);
        end
        check_idle("single");
    endtask

    task automatic test_mem_hold();
        for (int k = 0; k < 33; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd34, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd34, 1'b0);
            vecs++;
            if (stall !== 6'b011111 || ex_mc_done !== 1'b1 || ex_mc_cnt !== 6'd33 || ex_mc_busy !== (k == 0)) begin
                miss++;
                $display("FAIL mem_hold[%0d]: stall=%b done=%b cnt=%0d busy=%b, need 011111 1 33 %b", k, stall, ex_mc_done, ex_mc_cnt, ex_mc_busy, k == 0);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd34, 1'b0);
        vecs++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1 || ex_mc_busy !== 1'b0) begin
            miss++;
            $display("FAIL mem_release: stall=%b done=%b busy=%b, need 000000 1 0", stall, ex_mc_done, ex_mc_busy);
        end
        check_idle("mem_hold");
    endtask

    task automatic test_cancel();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd10, 1'b1);
        vecs++;
        if (stall !== 6'b000111 || ex_mc_done !== 1'b0 || ex_mc_cnt !== 6'd4) begin
            miss++;
            $display("FAIL cancel_cycle: stall=%b done=%b cnt=%0d, need 000111 0 4", stall, ex_mc_done, ex_mc_cnt);
        end
        check_idle("cancel");
        for (int k = 0; k < 2; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 1'b1);
        vecs++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b0) begin
            miss++;
            $display("FAIL cancel_noid: stall=%b done=%b, need 000000 0", stall, ex_mc_done);
        end
        check_idle("cancel2");
    endtask

    task automatic test_id_concurrent();
        run_op("id_len5", 6'd5, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        vecs++;
        if (stall !== 6'b000111 || ex_mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin
            miss++;
            $display("FAIL id_only: stall=%b busy=%b done=%b, need 000111 0 0", stall, ex_mc_busy, ex_mc_done);
        end
        check_idle("id_len5");
    endtask

    task automatic test_back_to_back();
        run_op("b2b_a", 6'd2, 1'b0);
        run_op("b2b_b", 6'd3, 1'b0);
        check_idle("b2b");
    endtask

    task automatic test_reset_midop();
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        vecs++;
        if ({stall, ex_mc_done, ex_mc_busy, ex_mc_cnt} !== 14'd0) begin
            miss++;
            $display("FAIL reset_midop: stall=%b done=%b busy=%b cnt=%0d, need all zero", stall, ex_mc_done, ex_mc_busy, ex_mc_cnt);
        end
        check_idle("reset_midop");
    endtask

    initial begin
        Rst_n = 1'b0;
        stallreq_from_id = 1'b0;
        stallreq_from_mem = 1'b0;
        ex_mc_start = 1'b0;
        ex_mc_len = 6'd0;
        ex_mc_cancel = 1'b0;
        test_reset();
        test_len2();
        test_div34();
        test_single_cycle();
        test_mem_hold();
        test_cancel();
        test_id_concurrent();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline stall controller for the 5-stage core. It merges stall requests from ID (load-use) and MEM with the EX multi-cycle requests that it generates itself (madd/msub, div). It drives the 6-bit stall vector consumed by pc_reg and by the if_id, id_ex, ex_mem and mem_wb pipeline registers. It also tells EX which cycle of a multi-cycle operation it is in, and when the result is final.

Parameters:
CNT_W, 6, width of the multi-cycle length and cycle counter (maximum length 2^CNT_W-1 = 63).

Ports:
Clk  in  1  clock, rising edge.
Rst_n  in  1  synchronous reset, active-low.
stallreq_from_id  in  1  ID requests a hold (load-use hazard).
stallreq_from_mem  in  1  MEM requests a hold (memory not ready).
ex_mc_start  in  1  level: the instruction in EX is multi-cycle; held while that instruction sits in EX.
ex_mc_len  in  CNT_W  total EX occupancy in cycles, including the start cycle; sampled on acceptance.
ex_mc_cancel  in  1  flush: abort any multi-cycle operation in progress.
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = STOP.
ex_mc_busy  out  1  multi-cycle operation in progress (state BUSY).
ex_mc_done  out  1  EX result is final this cycle.
ex_mc_cnt  out  CNT_W  current cycle index of the operation (0 in the start cycle).

Behaviour:
- Reset: Rst_n==0 at a rising edge:
  - state<=IDLE, cnt<=0, len_q<=0.
  - While Rst_n==0, all outputs are forced combinationally: stall=6'b000000, busy=0, done=0, cnt=0.
- States: IDLE, BUSY, DONE. The state is registered; stall/done/busy are combinational from state and inputs.
- IDLE:
  - If start && len>=2: stallreq_ex=1 this cycle and cnt_out=0.
    - Next: state=BUSY, cnt<=1, len_q<=len.
  - If start && len<=1: single-cycle operation.
    - done=1, stallreq_ex=0, state stays IDLE.
  - Otherwise: idle, all flags 0.
- BUSY:
  - cnt_out=cnt, busy=1.
  - If cnt<len_q-1: stallreq_ex=1, cnt<=cnt+1.
  - If cnt==len_q-1: done=1, stallreq_ex=0.
    - Next: DONE if stallreq_from_mem else IDLE.
- DONE:
  - Entered only when MEM holds EX after completion. done=1, stallreq_ex=0, start is ignored (it belongs to the same instruction).
  - Next: IDLE when stallreq_from_mem==0.
- Cancel: ex_mc_cancel has priority over all transitions.
  - Next state=IDLE, cnt<=0.
  - stallreq_ex and done are forced to 0 in the cancel cycle.
- Stall vector priority, first match wins:
  - stallreq_from_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_from_id -> 6'b000111
  - else -> 6'b000000
- Each of these patterns leaves stall[k]=STOP with stall[k+1]=NOSTOP, so the stage at k+1 receives a NOP bubble.
- The total EX stall for a length-L operation is exactly L-1 cycles. The EX instruction advances on the edge ending the done cycle (absent a MEM stall).
- A new start in IDLE is accepted on the cycle right after returning from BUSY/DONE (back-to-back operations).
- Counter never wraps: len_q<=63, and cnt saturates at len_q-1.
- Reset mid-operation: abort, return to IDLE, no residual stall.

Decomposition:
- Shared define package: STOP/NOSTOP, the stall patterns (STALL_NONE/ID/EX/MEM), the state encodings (MC_IDLE=2'b00, MC_BUSY=2'b01, MC_DONE=2'b10), and CNT_W.
- One natural sub-module: mc_seq (the IDLE/BUSY/DONE FSM plus counter, outputting stallreq_ex/busy/done/cnt).
- The top module adds the stall priority encoder and reset gating.

Test Plan:
- Reset: Rst_n=0 with all requests=1 -> stall=000000, done=0, cnt=0; after release with no requests -> stall stays 000000.
- ex_mc_start=1, len=2 -> cycle0: stall=001111, cnt=0; cycle1: stall=000000, done=1, cnt=1; cycle2: IDLE, busy=0.
- start with len=34 (div) -> stall=001111 for exactly 33 cycles, cnt counts 0..33, done only at cnt=33.
- len=34 with stallreq_from_mem=1 at cnt=33 held 3 cycles -> stall=011111, FSM stays in DONE with done=1 for those 3 cycles; start is ignored; IDLE after mem drops.
- start len=10 with ex_mc_cancel pulsed at cnt=4 -> that cycle stall drops to 000000 (or 000111 if stallreq_from_id=1), done=0; next cycle IDLE, cnt=0.
- stallreq_from_id=1 concurrently with start len=5 -> stall=001111 (EX wins) for 4 cycles, then 000111 in the done cycle.
